wb_pipe: RTL
============

WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the datapath width; legal values are 32 and 64.
REQ-002 Parameter RADDR_W, default 5, SHALL set the register address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 w_valid_i  input  1  SHALL indicate a valid instruction from the memory stage.
REQ-006 w_ready_o  output  1  SHALL indicate the stage accepts an instruction this cycle.
REQ-007 w_stall_i  input  1  SHALL indicate the register-file write port is busy; the held entry must not commit.
REQ-008 w_flush_i  input  1  SHALL be a pipeline kill of the entry being accepted this cycle.
REQ-009 w_pc_i  input  XLEN  SHALL carry the instruction PC.
REQ-010 w_alu_result_i  input  XLEN  SHALL carry the ALU result or the load address.
REQ-011 w_mem_rdata_i  input  XLEN  SHALL carry the naturally aligned memory word.
REQ-012 w_mem_size_i  input  3  SHALL carry load funct3: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
REQ-013 w_reg_mux_i  input  1  SHALL select load data (1) or ALU result (0).
REQ-014 w_reg_wen_i  input  1  SHALL request a register write.
REQ-015 w_reg_waddr_i  input  RADDR_W  SHALL carry the destination register.
REQ-016 w_reg_wen_o, w_reg_waddr_o, w_reg_wdata_o  output  1/RADDR_W/XLEN  SHALL form the register-file write port.
REQ-017 w_pc_o  output  XLEN  SHALL carry the PC of the held entry.
REQ-018 w_retire_o  output  1  SHALL pulse for one cycle per committed instruction.
REQ-019 w_exc_o  output  1  SHALL pulse for one cycle when a misaligned load commits.
REQ-020 w_instret_o  output  64  SHALL carry the retired-instruction count; present only when WB_INSTRET_EN is defined.

Function
REQ-021 The stage SHALL hold one entry register (valid, pc, wdata, waddr, wen, exc).
REQ-022 w_ready_o SHALL equal !(entry_valid && w_stall_i).
REQ-023 When w_valid_i && w_ready_o && !w_flush_i, the entry SHALL load on the next edge; latency is 1 cycle from acceptance to the output port.
REQ-024 When w_flush_i is high on an accept cycle, the entry SHALL become invalid; flush SHALL NOT affect an entry already held.
REQ-025 An entry SHALL commit in each cycle where entry_valid && !w_stall_i; on commit, w_retire_o = !exc.
REQ-026 w_reg_wen_o SHALL equal entry_valid && !w_stall_i && wen && !exc && (waddr != 0).
REQ-027 While stalled, the entry and all data outputs SHALL hold, w_reg_wen_o SHALL be 0, and the entry SHALL commit exactly once after the stall ends.
REQ-028 Byte offset SHALL be w_alu_result_i[2:0] for XLEN=64 and [1:0] for XLEN=32; the selected lane SHALL be offset*8 bits up.
REQ-029 lb/lh/lw SHALL sign-extend to XLEN; lbu/lhu/lwu SHALL zero-extend; ld SHALL pass the word unmodified.
REQ-030 When XLEN=32, ld and lwu SHALL behave as lw.
REQ-031 A load (mux=1) SHALL be misaligned when lh/lhu has an odd offset, lw/lwu has offset[1:0]!=0, or ld has offset!=0; exc SHALL be latched with the entry.
REQ-032 A misaligned entry SHALL suppress the write and retire, and SHALL assert w_exc_o on commit with w_pc_o holding its PC.
REQ-033 For mux=0, wdata SHALL be w_alu_result_i and exc SHALL be 0.

Reset
REQ-034 On rst, entry_valid SHALL clear to 0; w_reg_wen_o, w_retire_o, and w_exc_o SHALL be 0; w_pc_o, w_reg_wdata_o, and w_reg_waddr_o SHALL be 0; w_instret_o SHALL be 0.
REQ-035 Reset mid-stall SHALL discard the held entry without a commit.

Configuration
REQ-036 With WB_INSTRET_EN defined, a 64-bit counter SHALL increment on each w_retire_o pulse, wrapping from all-ones to 0, and SHALL drive w_instret_o.
REQ-037 Without WB_INSTRET_EN, the counter and the w_instret_o port SHALL be absent; all other behaviour is unchanged.

Verification
REQ-038 XLEN=64, lb, addr 0x...3, rdata 0x0000_0000_8000_0000 -> wdata 0xFFFF_FFFF_FFFF_FF80 one cycle later, wen=1.
REQ-039 lhu, addr 0x...5 -> w_exc_o=1, w_reg_wen_o=0, w_retire_o=0, and w_pc_o equals the input PC.
REQ-040 Hold w_stall_i=1 for 3 cycles with the entry held -> w_ready_o=0 and wen=0 throughout; a single wen/retire pulse follows the release.
REQ-041 ALU write to x0 -> wen=0 and retire=1; a flush on the accept cycle -> no retire.
REQ-042 WB_INSTRET_EN defined, counter preloaded to all-ones by a forced value, one retire -> w_instret_o=0.
REQ-043 XLEN=32, ld addr 0x...4 with rdata 0x8000_0001 -> wdata 0x8000_0001 with no exception.

Source files
------------

// File: rtl/wb_pipe.sv
// wb_pipe: single-entry writeback stage. Aligns and extends load data,
// flags misaligned loads, and drives the register-file write port and
// retire/exception pulses from one held entry.
// Optional feature macro: WB_INSTRET_EN adds a 64-bit retired-instruction
// counter on w_instret_o.
module wb_pipe #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_valid_i,
  output logic               w_ready_o,
  input  logic               w_stall_i,
  input  logic               w_flush_i,
  input  logic [XLEN-1:0]    w_pc_i,
  input  logic [XLEN-1:0]    w_alu_result_i,
  input  logic [XLEN-1:0]    w_mem_rdata_i,
  input  logic [2:0]         w_mem_size_i,
  input  logic               w_reg_mux_i,
  input  logic               w_reg_wen_i,
  input  logic [RADDR_W-1:0] w_reg_waddr_i,
  output logic               w_reg_wen_o,
  output logic [RADDR_W-1:0] w_reg_waddr_o,
  output logic [XLEN-1:0]    w_reg_wdata_o,
  output logic [XLEN-1:0]    w_pc_o,
  output logic               w_retire_o,
  output logic               w_exc_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]        w_instret_o
`endif
);

  // Shift the addressed lane down to bit 0, then extend by load type.
  // ld (and the unused 111 encoding) passes the word through on a 64-bit
  // datapath; on a 32-bit datapath ld and lwu collapse onto lw.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata,
                                               input logic [2:0]      off,
                                               input logic [2:0]      size);
    logic [XLEN-1:0]    lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    lane = rdata >> {off, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    w    = lane[31:0];
    case (size)
      3'b000:  load_ext = XLEN'(b);
      3'b001:  load_ext = XLEN'(h);
      3'b010:  load_ext = XLEN'(w);
      3'b100:  load_ext = XLEN'(lane[7:0]);
      3'b101:  load_ext = XLEN'(lane[15:0]);
      3'b110:  load_ext = XLEN'(lane[31:0]);
      default: begin
        if (XLEN == 64) load_ext = rdata;
        else            load_ext = XLEN'(w);
      end
    endcase
  endfunction

  // Natural-alignment check; on a 32-bit datapath off[2] is always 0, so the
  // doubleword case reduces to the word case.
  function automatic logic misaligned(input logic [2:0] off,
                                      input logic [2:0] size);
    case (size[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off[1:0] != 2'b00);
      2'b11:   misaligned = (off != 3'b000);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // ---- stage p0: incoming instruction, data formatting ----
  logic [2:0]      off_p0;
  logic [XLEN-1:0] wdata_p0;
  logic            exc_p0;
  logic            accept_p0;

  assign off_p0    = (XLEN == 64) ? w_alu_result_i[2:0] : {1'b0, w_alu_result_i[1:0]};
  assign accept_p0 = w_valid_i && w_ready_o && !w_flush_i;

  // Select write data and exception flag for the incoming instruction
  always_comb begin
    wdata_p0 = w_alu_result_i;
    exc_p0   = 1'b0;
    if (w_reg_mux_i) begin
      wdata_p0 = load_ext(w_mem_rdata_i, off_p0, w_mem_size_i);
      exc_p0   = misaligned(off_p0, w_mem_size_i);
    end
  end

  // ---- stage p1: held entry, commit ----
  logic               vld_p1;
  logic [XLEN-1:0]    pc_p1;
  logic [XLEN-1:0]    wdata_p1;
  logic [RADDR_W-1:0] waddr_p1;
  logic               wen_p1;
  logic               exc_p1;
  logic               commit_p1;

  // The slot is free to refill whenever it is empty or committing this cycle;
  // a flush only ever kills the instruction being offered, never the held one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      wdata_p1 <= '0;
      waddr_p1 <= '0;
      wen_p1   <= 1'b0;
      exc_p1   <= 1'b0;
    end else if (w_ready_o) begin
      vld_p1 <= w_valid_i && !w_flush_i;
      if (accept_p0) begin
        pc_p1    <= w_pc_i;
        wdata_p1 <= wdata_p0;
        waddr_p1 <= w_reg_waddr_i;
        wen_p1   <= w_reg_wen_i;
        exc_p1   <= exc_p0;
      end
    end
  end

  assign w_ready_o     = !(vld_p1 && w_stall_i);
  assign commit_p1     = vld_p1 && !w_stall_i;
  assign w_reg_wen_o   = commit_p1 && wen_p1 && !exc_p1 && (waddr_p1 != '0);
  assign w_retire_o    = commit_p1 && !exc_p1;
  assign w_exc_o       = commit_p1 && exc_p1;
  assign w_reg_waddr_o = waddr_p1;
  assign w_reg_wdata_o = wdata_p1;
  assign w_pc_o        = pc_p1;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Count retired instructions; wraps naturally from all-ones to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             instret_q <= '0;
    else if (w_retire_o) instret_q <= instret_q + 64'd1;
  end

  assign w_instret_o = instret_q;
`endif

endmodule
